// File: rtl/soc_sysid_pkg.sv
`default_nettype none
// ============================================================================
// Module  : soc_sysid_pkg
// Purpose : Shared definitions for the extended system-ID slave.
//           - Register word addresses.
//           - CAPS field layout.
//           - A byte-enable merge helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package soc_sysid_pkg;

  // Register word addresses, zero-extended to 8 bits so that any legal
  // ADDR_W (3..8) can be compared against them directly.
  localparam logic [7:0] ADDR_ID        = 8'd0;
  localparam logic [7:0] ADDR_TIMESTAMP = 8'd1;
  localparam logic [7:0] ADDR_VERSION   = 8'd2;
  localparam logic [7:0] ADDR_UPTIME_LO = 8'd3;
  localparam logic [7:0] ADDR_UPTIME_HI = 8'd4;
  localparam logic [7:0] ADDR_SCRATCH   = 8'd5;
  localparam logic [7:0] ADDR_CAPS      = 8'd6;
  localparam logic [7:0] ADDR_RDCOUNT   = 8'd7;

  // CAPS word layout
  localparam int CAPS_LAT_LSB     = 0;
  localparam int CAPS_LAT_W       = 4;
  localparam int CAPS_ADDRW_LSB   = 4;
  localparam int CAPS_ADDRW_W     = 4;
  localparam int CAPS_TICKDIV_LSB = 8;
  localparam int CAPS_TICKDIV_W   = 24;

  // Merge wdata into cur on the lanes selected by be.
  function automatic logic [31:0] apply_byteenable(
    input logic [31:0] cur,
    input logic [31:0] wdata,
    input logic [3:0]  be
  );
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/soc_sysid_uptime.sv
`default_nettype none
// ============================================================================
// Module  : soc_sysid_uptime
// Purpose : Free-running 64-bit uptime counter behind a prescaler. The
//           prescaler counts 0..TICK_DIV-1; the counter steps by one in the
//           cycle the prescaler wraps and itself wraps at 2^64-1.
// Ports   : clock   - system clock
//           reset_n - asynchronous active-low reset
//           count   - current uptime value
// Revision: 1.0 - initial release
// ============================================================================
module soc_sysid_uptime #(
  parameter int TICK_DIV = 50
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [63:0] count
);

  localparam logic [31:0] PRESC_LAST = 32'(TICK_DIV - 1);

  logic [31:0] presc_q, presc_d;
  logic [63:0] count_q, count_d;
  logic        tick;

  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? 32'd0 : presc_q + 32'd1;
    count_d = tick ? count_q + 64'd1 : count_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      count_q <= '0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/soc_system_sysid_ext.sv
`default_nettype none
// ============================================================================
// Module  : soc_system_sysid_ext
// Purpose : System-ID Avalon-MM slave with version/caps words, atomic 64-bit
//           uptime readout, byte-writable scratch and saturating read count.
//           Reads return after a fixed READ_LATENCY with readdatavalid.
// Ports   : clock         - system clock
//           reset_n       - asynchronous active-low reset
//           address       - word address
//           read / write  - access strobes, accepted every cycle
//           writedata     - write data
//           byteenable    - write byte lanes
//           readdata      - read data, zero unless readdatavalid
//           readdatavalid - read-data qualifier
// Revision: 1.0 - initial release
// ============================================================================
module soc_system_sysid_ext
  import soc_sysid_pkg::*;
#(
  parameter logic [31:0] SYSID_ID     = 32'hACD5_0002,
  parameter logic [31:0] TIMESTAMP    = 32'd0,
  parameter logic [31:0] VERSION      = 32'h0002_0000,
  parameter int          ADDR_W       = 3,
  parameter int          READ_LATENCY = 1,
  parameter int          TICK_DIV     = 50
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  logic [63:0] uptime;

  soc_sysid_uptime #(.TICK_DIV(TICK_DIV)) u_uptime (
    .clock   (clock),
    .reset_n (reset_n),
    .count   (uptime)
  );

  logic [7:0]  addr_ext;
  logic [31:0] caps;
  logic [31:0] rd_sel;

  logic [31:0] shadow_q,  shadow_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] rdcount_q, rdcount_d;

  logic [READ_LATENCY-1:0] pipe_vld_q,  pipe_vld_d;
  logic [31:0]             pipe_data_q [READ_LATENCY];
  logic [31:0]             pipe_data_d [READ_LATENCY];

  // Widening the address makes every address >= 8 fall into the default arm.
  assign addr_ext = 8'(address);

  always_comb begin
    caps = '0;
    caps[CAPS_LAT_LSB     +: CAPS_LAT_W]     = CAPS_LAT_W'(READ_LATENCY);
    caps[CAPS_ADDRW_LSB   +: CAPS_ADDRW_W]   = CAPS_ADDRW_W'(ADDR_W);
    caps[CAPS_TICKDIV_LSB +: CAPS_TICKDIV_W] = CAPS_TICKDIV_W'(TICK_DIV);
  end

  // Read mux uses pre-write state, so a same-cycle write is not visible.
  always_comb begin
    rd_sel = '0;
    case (addr_ext)
      ADDR_ID:        rd_sel = SYSID_ID;
      ADDR_TIMESTAMP: rd_sel = TIMESTAMP;
      ADDR_VERSION:   rd_sel = VERSION;
      ADDR_UPTIME_LO: rd_sel = uptime[31:0];
      ADDR_UPTIME_HI: rd_sel = shadow_q;
      ADDR_SCRATCH:   rd_sel = scratch_q;
      ADDR_CAPS:      rd_sel = caps;
      ADDR_RDCOUNT:   rd_sel = rdcount_q;
      default:        rd_sel = '0;
    endcase
  end

  always_comb begin
    shadow_d  = shadow_q;
    scratch_d = scratch_q;
    rdcount_d = rdcount_q;

    // High word is frozen in the same cycle the low word is sampled.
    if (read && (addr_ext == ADDR_UPTIME_LO)) shadow_d = uptime[63:32];

    if (write && (addr_ext == ADDR_SCRATCH))
      scratch_d = apply_byteenable(scratch_q, writedata, byteenable);

    // Clear has priority over a concurrent read increment.
    if (write && (addr_ext == ADDR_RDCOUNT))
      rdcount_d = '0;
    else if (read && (rdcount_q != 32'hFFFF_FFFF))
      rdcount_d = rdcount_q + 32'd1;
  end

  // Idle stages carry zero so readdata is zero between returns.
  always_comb begin
    pipe_vld_d[0]  = read;
    pipe_data_d[0] = read ? rd_sel : 32'd0;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_data_d[i] = pipe_data_q[i-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q    <= '0;
      scratch_q   <= '0;
      rdcount_q   <= '0;
      pipe_vld_q  <= '0;
      pipe_data_q <= '{default: '0};
    end else begin
      shadow_q    <= shadow_d;
      scratch_q   <= scratch_d;
      rdcount_q   <= rdcount_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_data_q <= pipe_data_d;
    end
  end

  assign readdata      = pipe_data_q[READ_LATENCY-1];
  assign readdatavalid = pipe_vld_q[READ_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_soc_system_sysid_ext.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_soc_system_sysid_ext
// Purpose : Self-checking bench. Instance A uses default parameters; instance
//           B uses READ_LATENCY=2, ADDR_W=4, TICK_DIV=1. Both share clock and
//           reset.
// Revision: 1.0 - initial release
// ============================================================================
module tb_soc_system_sysid_ext;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;

  logic [2:0]  a_address;
  logic        a_read, a_write;
  logic [31:0] a_wdata;
  logic [3:0]  a_be;
  logic [31:0] a_rdata;
  logic        a_rvalid;

  logic [3:0]  b_address;
  logic        b_read, b_write;
  logic [31:0] b_wdata;
  logic [3:0]  b_be;
  logic [31:0] b_rdata;
  logic        b_rvalid;

  soc_system_sysid_ext dut_a (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (a_address),
    .read          (a_read),
    .write         (a_write),
    .writedata     (a_wdata),
    .byteenable    (a_be),
    .readdata      (a_rdata),
    .readdatavalid (a_rvalid)
  );

  soc_system_sysid_ext #(
    .READ_LATENCY (2),
    .ADDR_W       (4),
    .TICK_DIV     (1)
  ) dut_b (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (b_address),
    .read          (b_read),
    .write         (b_write),
    .writedata     (b_wdata),
    .byteenable    (b_be),
    .readdata      (b_rdata),
    .readdatavalid (b_rvalid)
  );

  int total = 0;
  int bad   = 0;
  int a_rdcnt = 0;   // model of instance A's read counter

  typedef struct {
    bit          on_b;
    logic [3:0]  addr;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Single read on A (latency 1): issue, then sample one cycle later.
  task automatic a_rd(input logic [2:0] ad, output logic [31:0] d, output logic v);
    @(posedge clock); #1;
    a_address = ad; a_read = 1'b1;
    @(posedge clock); #1;
    a_read = 1'b0;
    d = a_rdata; v = a_rvalid;
    a_rdcnt++;
  endtask

  task automatic a_rdchk(input logic [2:0] ad, input logic [31:0] exp, input string nm);
    logic [31:0] d;
    logic        v;
    a_rd(ad, d, v);
    chk({nm, "_vld"}, 32'(v), 32'd1);
    chk(nm, d, exp);
  endtask

  task automatic a_wr(input logic [2:0] ad, input logic [31:0] wd, input logic [3:0] be);
    @(posedge clock); #1;
    a_address = ad; a_write = 1'b1; a_wdata = wd; a_be = be;
    @(posedge clock); #1;
    a_write = 1'b0;
    if (ad == 3'd7) a_rdcnt = 0;
  endtask

  // Read and write on A in the same cycle.
  task automatic a_rw(input logic [2:0] ad, input logic [31:0] wd, input logic [3:0] be,
                      input logic [31:0] exp, input string nm);
    @(posedge clock); #1;
    a_address = ad; a_read = 1'b1; a_write = 1'b1; a_wdata = wd; a_be = be;
    @(posedge clock); #1;
    a_read = 1'b0; a_write = 1'b0;
    chk({nm, "_vld"}, 32'(a_rvalid), 32'd1);
    chk(nm, a_rdata, exp);
    if (ad == 3'd7) a_rdcnt = 0; else a_rdcnt++;
  endtask

  // Single read on B (latency 2): nothing at T+1, data at T+2.
  task automatic b_rdchk(input logic [3:0] ad, input logic [31:0] exp, input string nm);
    @(posedge clock); #1;
    b_address = ad; b_read = 1'b1;
    @(posedge clock); #1;
    b_read = 1'b0;
    chk({nm, "_early"}, 32'(b_rvalid), 32'd0);
    @(posedge clock); #1;
    chk({nm, "_vld"}, 32'(b_rvalid), 32'd1);
    chk(nm, b_rdata, exp);
  endtask

  // Three back-to-back reads on B.
  task automatic b_burst3(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                          input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                          input string nm);
    @(posedge clock); #1;
    b_address = a0; b_read = 1'b1;
    @(posedge clock); #1;
    b_address = a1;
    chk({nm, "_t1_vld"}, 32'(b_rvalid), 32'd0);
    @(posedge clock); #1;
    b_address = a2;
    chk({nm, "_t2_vld"}, 32'(b_rvalid), 32'd1);
    chk({nm, "_t2"}, b_rdata, e0);
    @(posedge clock); #1;
    b_read = 1'b0;
    chk({nm, "_t3_vld"}, 32'(b_rvalid), 32'd1);
    chk({nm, "_t3"}, b_rdata, e1);
    @(posedge clock); #1;
    chk({nm, "_t4_vld"}, 32'(b_rvalid), 32'd1);
    chk({nm, "_t4"}, b_rdata, e2);
    @(posedge clock); #1;
    chk({nm, "_t5_vld"}, 32'(b_rvalid), 32'd0);
    chk({nm, "_t5"}, b_rdata, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d_prev, d_cur;
    logic        v;

    reset_n   = 1'b0;
    a_address = '0; a_read = 1'b0; a_write = 1'b0; a_wdata = '0; a_be = '0;
    b_address = '0; b_read = 1'b0; b_write = 1'b0; b_wdata = '0; b_be = '0;

    // Vector table: single reads, each on one instance.
    vecs[0]  = '{1'b0, 4'd0,  32'hACD5_0002, "a_id"};
    vecs[1]  = '{1'b0, 4'd1,  32'h0000_0000, "a_timestamp"};
    vecs[2]  = '{1'b0, 4'd2,  32'h0002_0000, "a_version"};
    vecs[3]  = '{1'b0, 4'd7,  32'd3,         "a_rdcount_3"};
    vecs[4]  = '{1'b0, 4'd6,  32'h0000_3231, "a_caps"};
    vecs[5]  = '{1'b0, 4'd7,  32'd5,         "a_rdcount_5"};
    vecs[6]  = '{1'b1, 4'd0,  32'hACD5_0002, "b_id"};
    vecs[7]  = '{1'b1, 4'd9,  32'h0000_0000, "b_unmapped_9"};
    vecs[8]  = '{1'b1, 4'd15, 32'h0000_0000, "b_unmapped_15"};
    vecs[9]  = '{1'b1, 4'd6,  32'h0000_0142, "b_caps"};
    vecs[10] = '{1'b1, 4'd5,  32'h0000_0000, "b_scratch_rst"};
    vecs[11] = '{1'b1, 4'd2,  32'h0002_0000, "b_version"};
    vecs[12] = '{1'b1, 4'd7,  32'd6,         "b_rdcount_6"};

    repeat (3) @(posedge clock);
    #1;
    chk("rst_a_vld",  32'(a_rvalid), 32'd0);
    chk("rst_a_data", a_rdata,       32'd0);
    chk("rst_b_vld",  32'(b_rvalid), 32'd0);
    chk("rst_b_data", b_rdata,       32'd0);
    reset_n = 1'b1;
    a_rdcnt = 0;

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].on_b) b_rdchk(vecs[i].addr, vecs[i].exp, vecs[i].nm);
      else              a_rdchk(vecs[i].addr[2:0], vecs[i].exp, vecs[i].nm);
    end

    // Back-to-back reads returned in order at T+2..T+4.
    b_burst3(4'd0, 4'd1, 4'd2, 32'hACD5_0002, 32'h0, 32'h0002_0000, "b_b2b");

    // Atomic LO/HI: LO sampled at 1_FFFFFFFF, HI read after the live
    // high word has moved on to 2.
    @(posedge clock); #1;
    force dut_b.u_uptime.count_q = 64'h0000_0001_FFFF_FFFF;
    b_address = 4'd3; b_read = 1'b1;
    @(posedge clock); #1;
    release dut_b.u_uptime.count_q;
    b_address = 4'd0;
    chk("up_t1_vld", 32'(b_rvalid), 32'd0);
    @(posedge clock); #1;
    b_address = 4'd4;
    chk("up_lo", b_rdata, 32'hFFFF_FFFF);
    @(posedge clock); #1;
    b_read = 1'b0;
    chk("up_mid", b_rdata, 32'hACD5_0002);
    @(posedge clock); #1;
    chk("up_hi_vld", 32'(b_rvalid), 32'd1);
    chk("up_hi_shadow", b_rdata, 32'h0000_0001);

    // Byte-enabled scratch writes.
    a_wr(3'd5, 32'h1122_3344, 4'b1111);
    a_wr(3'd5, 32'hAABB_CCDD, 4'b0101);
    a_rdchk(3'd5, 32'h11BB_33DD, "scratch_be");
    a_rw(3'd5, 32'hFFFF_FFFF, 4'b1111, 32'h11BB_33DD, "rw_scratch_old");
    a_rdchk(3'd5, 32'hFFFF_FFFF, "rw_scratch_new");

    // Read-only word ignores writes.
    a_wr(3'd0, 32'h0, 4'b1111);
    a_rdchk(3'd0, 32'hACD5_0002, "id_ro");

    // Read counter: same-cycle read+write returns old value, clear wins.
    a_rw(3'd7, 32'h0, 4'b1111, 32'(a_rdcnt), "rdcnt_rw_old");
    a_rdchk(3'd7, 32'd0, "rdcnt_cleared");
    a_rdchk(3'd7, 32'd1, "rdcnt_after_clear");

    // Prescaler: reads 50 cycles apart see exactly one uptime step.
    a_rd(3'd3, d_prev, v);
    for (int k = 0; k < 5; k++) begin
      repeat (48) @(posedge clock);
      a_rd(3'd3, d_cur, v);
      chk("tick_div50_step", d_cur - d_prev, 32'd1);
      d_prev = d_cur;
    end

    // Reset during an in-flight read on B: no valid for it.
    @(posedge clock); #1;
    b_address = 4'd0; b_read = 1'b1;
    @(posedge clock); #1;
    b_read  = 1'b0;
    reset_n = 1'b0;
    a_rdcnt = 0;
    chk("midrst_t1_vld", 32'(b_rvalid), 32'd0);
    @(posedge clock); #1;
    chk("midrst_t2_vld",  32'(b_rvalid), 32'd0);
    chk("midrst_t2_data", b_rdata,       32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("midrst_after_vld", 32'(b_rvalid), 32'd0);

    a_rdchk(3'd6, 32'h0000_3231, "caps_after_rst");
    a_rdchk(3'd7, 32'd1,         "rdcnt_after_rst");
    b_rdchk(4'd4, 32'd0,         "b_shadow_after_rst");
    b_rdchk(4'd0, 32'hACD5_0002, "b_id_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/soc_system_sysid_ext.md
Name: soc_system_sysid_ext

Overview:
Second-generation system-ID Avalon-MM slave for the HPS lightweight bridge. It keeps the fixed ID and build-timestamp words and adds these functions:
- version and capability words
- a free-running 64-bit uptime counter, readable atomically through a shadow register
- a byte-writable scratch register
- a saturating read counter

Reads are pipelined with a parametrised fixed latency and readdatavalid.

Parameters:
SYSID_ID, 32'hACD5_0002, system ID word (addr 0)
TIMESTAMP, 32'd0, build timestamp in Unix seconds (addr 1)
VERSION, 32'h0002_0000, IP version, major[31:16] minor[15:0] (addr 2)
ADDR_W, 3, word-address width; legal range 3..8; addresses >= 8 are unmapped
READ_LATENCY, 1, cycles from read acceptance to readdatavalid; legal range 1..4
TICK_DIV, 50, clock cycles per uptime increment; >= 1 (50 gives 1 us at 50 MHz)

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
address  input  ADDR_W  word address
read  input  1  read request; accepted every cycle (no waitrequest)
write  input  1  write request; accepted every cycle
writedata  input  32  write data
byteenable  input  4  byte lanes for write
readdata  output  32  read data; valid only when readdatavalid=1
readdatavalid  output  1  read-data qualifier

Behaviour:
- Reset (reset_n=0, asynchronous): readdata=0, readdatavalid=0, read pipeline flushed, uptime=0, prescaler=0, shadow=0, scratch=0, read counter=0.
- Register map (word addresses):
  - 0 ID (RO)
  - 1 TIMESTAMP (RO)
  - 2 VERSION (RO)
  - 3 UPTIME_LO (RO); reading it latches uptime[63:32] into the shadow
  - 4 UPTIME_HI (RO); returns the shadow, not the live value
  - 5 SCRATCH (RW, byte-enabled)
  - 6 CAPS (RO): [3:0]=READ_LATENCY, [7:4]=ADDR_W, [31:8]=TICK_DIV[23:0]
  - 7 RDCOUNT (RO value); any write clears it to 0
  - All other addresses read 0. Writes to RO or unmapped addresses are ignored.
- Read pipeline:
  - Read data is selected combinationally at the acceptance cycle T and carried through a shift pipeline of READ_LATENCY stages.
  - readdata and readdatavalid are registered; readdatavalid=1 exactly in cycle T+READ_LATENCY.
  - Back-to-back reads are allowed at one per cycle, returned in order.
  - Between returns, readdata is held at 0.
- UPTIME_LO returns the live uptime[31:0] at cycle T. The shadow captures uptime[63:32] from the same cycle T, so a LO-then-HI pair is atomic.
- Uptime counter:
  - The prescaler counts 0..TICK_DIV-1. Uptime increments by 1 in the cycle the prescaler wraps.
  - With TICK_DIV=1, uptime increments every cycle.
  - Uptime wraps from 2^64-1 to 0.
- Scratch register: each byte lane i is updated only when byteenable[i]=1.
- Read counter:
  - Increments on every accepted read, at any address, including reads of RDCOUNT itself.
  - A read of RDCOUNT returns the pre-increment value.
  - Saturates at 32'hFFFF_FFFF.
  - If a write to addr 7 and a read occur in the same cycle, the clear wins; the value is 0 afterwards.
- Simultaneous read and write in one cycle: both are performed. The read returns the pre-write value; the write takes effect the next cycle.
- Reset asserted mid-read: in-flight reads are dropped and no readdatavalid is produced for them. After deassertion the first accepted read behaves normally.

Decomposition:
- Package soc_sysid_pkg holds:
  - register address constants (ADDR_ID .. ADDR_RDCOUNT)
  - CAPS field offsets
  - a helper that applies byteenable to a 32-bit word
- One natural sub-module: soc_sysid_uptime (prescaler plus 64-bit counter; outputs count[63:0]).
- The read pipeline and register file stay in the top module.

Test Plan:
- Reset, then read addr 0, 1, 2 back-to-back with READ_LATENCY=2 -> readdatavalid high in cycles T+2, T+3, T+4 with readdata 32'hACD5_0002, 0, 32'h0002_0000.
- TICK_DIV=1, force uptime to 64'h0000_0001_FFFF_FFFF, read addr 3 then addr 4 -> returns 32'hFFFF_FFFF then 32'h0000_0001, even though the live high word has become 2.
- Write 32'h1122_3344 to addr 5 with byteenable=4'b1111, then write 32'hAABB_CCDD with byteenable=4'b0101, read addr 5 -> 32'h11BB_33DD.
- 3 reads of any address, then read addr 7 -> returns 3. Write addr 7 in the same cycle as a read, then read addr 7 -> returns 0.
- Read addr 9 (ADDR_W=4) -> readdata 0, readdatavalid asserted. Write addr 0 with 32'h0, then read addr 0 -> still 32'hACD5_0002.
- Issue a read, assert reset_n=0 one cycle later -> no readdatavalid. After release, read addr 6 with defaults -> 32'h0000_3231.
